// File: rtl/csa_pipe.sv
// rtl/csa_pipe.sv - two-stage pipelined carry-select adder/subtractor with valid/ready flow control
// Stage 1 precomputes dual block sums; stage 2 ripples block carries to select the result.
module csa_pipe #(
  parameter int BLOCK_W    = 8,
  parameter int NUM_BLOCKS = 4,
  localparam int WIDTH     = BLOCK_W * NUM_BLOCKS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  logic v1_q, v1_d, v2_q, v2_d;
  logic [NUM_BLOCKS-1:0][BLOCK_W-1:0] s0_q, s0_d, s1_q, s1_d;
  logic [NUM_BLOCKS-1:0] c0_q, c0_d, c1_q, c1_d;
  logic cin_q, cin_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic c_out_q, c_out_d, ovf_q, ovf_d;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff, accept, adv2;
  logic [BLOCK_W:0] blk0, blk1;
  logic [WIDTH-1:0] sel_sum;
  logic             sel_c;

  always_comb begin
    b_eff    = sub ? ~b : b;
    cin_eff  = sub | c_in;
    adv2     = v1_q & (~v2_q | out_ready);
    in_ready = ~v1_q | adv2;
    accept   = in_valid & in_ready;
    v1_d     = accept | (v1_q & ~adv2);
    v2_d     = adv2 | (v2_q & ~out_ready);

    s0_d    = s0_q;
    s1_d    = s1_q;
    c0_d    = c0_q;
    c1_d    = c1_q;
    cin_d   = cin_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    blk0    = '0;
    blk1    = '0;
    if (accept) begin
      for (int k = 0; k < NUM_BLOCKS; k++) begin
        blk0    = {1'b0, a[k*BLOCK_W +: BLOCK_W]} + {1'b0, b_eff[k*BLOCK_W +: BLOCK_W]};
        blk1    = blk0 + (BLOCK_W+1)'(1);
        s0_d[k] = blk0[BLOCK_W-1:0];
        c0_d[k] = blk0[BLOCK_W];
        s1_d[k] = blk1[BLOCK_W-1:0];
        c1_d[k] = blk1[BLOCK_W];
      end
      cin_d   = cin_eff;
      a_msb_d = a[WIDTH-1];
      b_msb_d = b_eff[WIDTH-1];
    end

    // Carry ripples one mux per block rather than one per bit.
    sel_c   = cin_q;
    sel_sum = '0;
    for (int k = 0; k < NUM_BLOCKS; k++) begin
      if (sel_c) begin
        sel_sum[k*BLOCK_W +: BLOCK_W] = s1_q[k];
        sel_c                         = c1_q[k];
      end else begin
        sel_sum[k*BLOCK_W +: BLOCK_W] = s0_q[k];
        sel_c                         = c0_q[k];
      end
    end

    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    if (adv2) begin
      sum_d   = sel_sum;
      c_out_d = sel_c;
      ovf_d   = (a_msb_q == b_msb_q) & (sel_sum[WIDTH-1] != a_msb_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      s0_q    <= '0;
      s1_q    <= '0;
      c0_q    <= '0;
      c1_q    <= '0;
      cin_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      cin_q   <= cin_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = v2_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule
